sha3_stream_feeder: RTL

Parametrised message feeder for the SHA3 burst-master path: fetches a message of arbitrary byte length from OCM through the burst read master, buffers bus words in an internal FIFO, and splits them into lanes for the keccak core with correct last-lane and partial-byte signalling. Adds bus/lane width and FIFO depth parameters, credit-based read issue, a zero-length and exact-multiple final-lane rule, base addressing, abort, and back-to-back messages without reset. Sits between the AXI burst master and the keccak core, controlled by the slave register file.

---
 rtl/sha3_stream_feeder.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sha3_stream_feeder.sv
// Streams a byte-length message from OCM through the burst read master into keccak lanes.
// Single-word bursts are credit-gated on FIFO occupancy; the lane FSM handles partial and empty final lanes.
module sha3_stream_feeder #(
   parameter int BUS_W      = 128,
   parameter int LANE_W     = 64,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 16,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [LEN_W-1:0]  i_num_bytes,
   output logic              o_rd_req,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic              i_rd_active,
   input  logic              i_rd_done,
   input  logic [BUS_W-1:0]  i_bus_data,
   input  logic              i_bus_valid,
   output logic [LANE_W-1:0] o_k_in,
   output logic              o_k_in_ready,
   output logic              o_k_is_last,
   output logic [2:0]        o_k_byte_num,
   input  logic              i_k_buffer_full,
   input  logic              i_k_out_ready,
   output logic              o_busy,
   output logic              o_done
);
   localparam int BPW = BUS_W / 8;
   localparam int LPW = BUS_W / LANE_W;
   localparam int LBY = LANE_W / 8;
   localparam int BSH = $clog2(BPW);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LIW = (LPW > 1) ? $clog2(LPW) : 1;

   typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT_ACT, R_WAIT_DONE} rstate_t;
   typedef enum logic [2:0] {L_IDLE, L_FETCH, L_ISSUE, L_WAIT_HASH, L_DONE} lstate_t;

   rstate_t           r_rstate;
   lstate_t           r_lstate;
   logic              r_drain;
   logic [LEN_W:0]    r_words_left;
   logic [LEN_W-1:0]  r_index;
   logic [ADDR_W-1:0] r_base;
   logic              r_rd_req;
   logic [ADDR_W-1:0] r_rd_addr;

   logic [BUS_W-1:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr, r_rptr;
   logic [AW:0]       r_count;
   logic [BUS_W-1:0]  r_fifo_q;
   logic              r_overflow;

   logic [LEN_W-1:0]  r_rem;
   logic [LIW-1:0]    r_lane_idx;
   logic              r_empty_lane;
   logic [LANE_W-1:0] r_k_in;
   logic              r_k_in_ready, r_k_is_last;
   logic [2:0]        r_k_byte_num;
   logic              r_busy, r_done;

   logic              w_empty, w_full, w_pop, w_wr, w_abort, w_start, w_outstanding;
   logic [LEN_W:0]    w_words;
   logic [LANE_W-1:0] w_lane;

   assign w_empty       = (r_count == '0);
   assign w_full        = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_abort       = i_abort && r_busy;
   assign w_start       = i_start && !i_abort && !r_busy && (r_rstate == R_IDLE);
   assign w_outstanding = (r_rstate == R_WAIT_ACT) || (r_rstate == R_WAIT_DONE);
   assign w_pop         = (r_lstate == L_FETCH) && !w_empty && !w_abort;
   // Data of a burst that outlived an abort is dropped on the floor.
   assign w_wr          = i_bus_valid && !r_drain && !w_abort && (!w_full || w_pop);
   assign w_words       = ({1'b0, i_num_bytes} + (LEN_W+1)'(BPW - 1)) >> BSH;
   assign w_lane        = LANE_W'(r_fifo_q >> (int'(r_lane_idx) * LANE_W));

   // Read side: one single-word burst in flight at most.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rstate     <= R_IDLE;
         r_drain      <= 1'b0;
         r_words_left <= '0;
         r_index      <= '0;
         r_base       <= '0;
         r_rd_req     <= 1'b0;
         r_rd_addr    <= '0;
      end else begin
         r_rd_req <= 1'b0;
         if (w_abort) begin
            if (w_outstanding) r_drain <= 1'b1;
            else r_rstate <= R_IDLE;
         end else if (w_start) begin
            r_words_left <= w_words;
            r_index      <= '0;
            r_base       <= i_base_addr;
            r_rstate     <= (w_words == '0) ? R_IDLE : R_REQ;
         end else begin
            case (r_rstate)
               R_REQ: begin
                  if (r_words_left == '0) r_rstate <= R_IDLE;
                  else if (r_count < (AW+1)'(FIFO_DEPTH)) begin
                     r_rd_req  <= 1'b1;
                     r_rd_addr <= r_base + (ADDR_W'(r_index) << BSH);
                     r_rstate  <= R_WAIT_ACT;
                  end
               end
               R_WAIT_ACT: begin
                  if (r_drain && i_rd_done) begin
                     r_drain  <= 1'b0;
                     r_rstate <= R_IDLE;
                  end else if (i_rd_active) r_rstate <= R_WAIT_DONE;
               end
               R_WAIT_DONE: begin
                  if (i_rd_done) begin
                     if (r_drain) begin
                        r_drain  <= 1'b0;
                        r_rstate <= R_IDLE;
                     end else begin
                        r_index      <= r_index + 1'b1;
                        r_words_left <= r_words_left - 1'b1;
                        r_rstate     <= (r_words_left == (LEN_W+1)'(1)) ? R_IDLE : R_REQ;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= i_bus_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_fifo_q   <= '0;
         r_overflow <= 1'b0;
      end else if (w_abort) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_start) r_overflow <= 1'b0;
         else if (i_bus_valid && !r_drain && w_full && !w_pop) r_overflow <= 1'b1;
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_pop) begin
            r_rptr   <= r_rptr + 1'b1;
            r_fifo_q <= r_mem[r_rptr];
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Lane side: at most one lane every other cycle, gated by last cycle's buffer_full.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lstate     <= L_IDLE;
         r_rem        <= '0;
         r_lane_idx   <= '0;
         r_empty_lane <= 1'b0;
         r_k_in       <= '0;
         r_k_in_ready <= 1'b0;
         r_k_is_last  <= 1'b0;
         r_k_byte_num <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_k_in_ready <= 1'b0;
         if (w_abort) begin
            r_lstate     <= L_IDLE;
            r_k_in       <= '0;
            r_k_is_last  <= 1'b0;
            r_k_byte_num <= '0;
            r_done       <= 1'b0;
            r_busy       <= w_outstanding;
         end else if (w_start) begin
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_rem        <= i_num_bytes;
            r_lane_idx   <= '0;
            r_empty_lane <= (i_num_bytes == '0);
            r_lstate     <= (i_num_bytes == '0) ? L_ISSUE : L_FETCH;
         end else begin
            if (r_drain && i_rd_done) r_busy <= 1'b0;
            case (r_lstate)
               L_FETCH: if (!w_empty) r_lstate <= L_ISSUE;
               L_ISSUE: begin
                  if (!i_k_buffer_full && !r_k_in_ready) begin
                     r_k_in_ready <= 1'b1;
                     if (r_empty_lane) begin
                        r_k_in       <= '0;
                        r_k_is_last  <= 1'b1;
                        r_k_byte_num <= '0;
                        r_lstate     <= L_WAIT_HASH;
                     end else if (r_rem > LEN_W'(LBY)) begin
                        r_k_in       <= w_lane;
                        r_k_is_last  <= 1'b0;
                        r_k_byte_num <= '0;
                        r_rem        <= r_rem - LEN_W'(LBY);
                        if (r_lane_idx == LIW'(LPW - 1)) begin
                           r_lane_idx <= '0;
                           r_lstate   <= L_FETCH;
                        end else r_lane_idx <= r_lane_idx + 1'b1;
                     end else if (r_rem == LEN_W'(LBY)) begin
                        r_k_in       <= w_lane;
                        r_k_is_last  <= 1'b0;
                        r_k_byte_num <= '0;
                        r_rem        <= '0;
                        r_empty_lane <= 1'b1;
                     end else begin
                        r_k_in       <= w_lane;
                        r_k_is_last  <= 1'b1;
                        r_k_byte_num <= r_rem[2:0];
                        r_lstate     <= L_WAIT_HASH;
                     end
                  end
               end
               L_WAIT_HASH: begin
                  if (i_k_out_ready) begin
                     r_lstate <= L_DONE;
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_rd_req     = r_rd_req;
   assign o_rd_addr    = r_rd_addr;
   assign o_k_in       = r_k_in;
   assign o_k_in_ready = r_k_in_ready;
   assign o_k_is_last  = r_k_is_last;
   assign o_k_byte_num = r_k_byte_num;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
endmodule
